// File: rtl/bcd_counter_display.sv
// 4-digit BCD up/down event counter with a registered, multiplexed common-anode 7-segment scan driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero digit (digit 0 always shown).
module bcd_counter_display #(
  parameter logic [15:0] INIT_VALUE = 16'h0000,
  parameter int unsigned DP_DIGIT   = 4
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        count_tick,
  input  logic        scan_tick,
  input  logic        enable,
  input  logic        up,
  input  logic        clear,
  output logic [15:0] value,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_state_e;

  scan_state_e state_q, state_d;
  logic [15:0] value_q, value_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        step_carry;
  logic [1:0]  scan_idx;
  logic [3:0]  sel_nibble;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Ripple step: carry/borrow enters at the ones digit; surviving it past digit 3 is a wrap.
  always_comb begin
    value_d    = value_q;
    wrap_d     = 1'b0;
    step_carry = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (count_tick && enable) begin
      step_carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (step_carry) begin
          if (up) begin
            if (value_q[4*i +: 4] == 4'd9) begin
              value_d[4*i +: 4] = 4'd0;
            end else begin
              value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
              step_carry        = 1'b0;
            end
          end else begin
            if (value_q[4*i +: 4] == 4'd0) begin
              value_d[4*i +: 4] = 4'd9;
            end else begin
              value_d[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
              step_carry        = 1'b0;
            end
          end
        end
      end
      wrap_d = step_carry;
    end
  end

  always_comb begin
    state_d = state_q;
    if (scan_tick) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        DIG3:    state_d = DIG0;
        default: state_d = DIG0;
      endcase
    end
  end

  assign scan_idx   = state_q;
  assign sel_nibble = value_q[{scan_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digit i and every digit above it are zero; digit 0 is never blank.
  logic [3:0] lead_zero;
  assign lead_zero[3] = (value_q[15:12] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (value_q[11:8] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (value_q[7:4] == 4'd0);
  assign lead_zero[0] = 1'b0;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << scan_idx);
    seg_d = seg_decode(sel_nibble);
    dp_d  = ({30'd0, scan_idx} == DP_DIGIT[31:0]) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (lead_zero[scan_idx]) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q <= DIG0;
      value_q <= INIT_VALUE;
      wrap_q  <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: directed scenarios plus random traffic checked by an integer-arithmetic model.
module tb_bcd_counter_display;

  localparam logic [15:0] INIT_VALUE = 16'h0000;
  localparam int          INIT_INT   = 0;
  localparam int          DP_DIGIT   = 2;

  logic        clock_in;
  logic        reset_n;
  logic        count_tick;
  logic        scan_tick;
  logic        enable;
  logic        up;
  logic        clear;
  logic [15:0] value;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests_run = 0;
  int fails     = 0;

  bcd_counter_display #(
    .INIT_VALUE(INIT_VALUE),
    .DP_DIGIT  (DP_DIGIT)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .count_tick(count_tick),
    .scan_tick (scan_tick),
    .enable    (enable),
    .up        (up),
    .clear     (clear),
    .value     (value),
    .wrap      (wrap),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // clock
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // reference model: integer count, digit index 0..3, segment lookup table
  int         pow10 [4]   = '{1, 10, 100, 1000};
  logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         m_val;
  int         m_idx;
  logic       m_wrap;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [28:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((v / pow10[i]) % 10);
    return b;
  endfunction

  always @(posedge clock_in) begin : model
    int d;
    if (!reset_n) begin
      m_val  = INIT_INT;
      m_wrap = 1'b0;
      m_idx  = 0;
      m_an   = 4'hF;
      m_seg  = 7'h7F;
      m_dp   = 1'b1;
    end else begin
      d     = (m_val / pow10[m_idx]) % 10;
      m_an  = 4'hF;
      m_an[m_idx] = 1'b0;
      m_seg = seg_tab[d];
      m_dp  = (m_idx == DP_DIGIT) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && m_val < pow10[m_idx]) begin
        m_seg = 7'h7F;
        m_dp  = 1'b1;
      end
`endif
      if (clear) begin
        m_val  = 0;
        m_wrap = 1'b0;
      end else if (count_tick && enable) begin
        if (up) begin
          m_wrap = (m_val == 9999);
          m_val  = (m_val + 1) % 10000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 9999) % 10000;
        end
      end else begin
        m_wrap = 1'b0;
      end
      if (scan_tick) m_idx = (m_idx + 1) % 4;
    end
    exp_q.push_back({to_bcd(m_val), m_wrap, m_an, m_seg, m_dp});
  end

  // scoreboard monitor: one expected entry per clock, compared mid-cycle
  always @(negedge clock_in) begin : monitor
    logic [28:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run += 5;
      if (value !== e[28:13]) begin fails++; $display("FAIL sb_value t=%0t got %h exp %h", $time, value, e[28:13]); end
      if (wrap  !== e[12])    begin fails++; $display("FAIL sb_wrap t=%0t got %b exp %b", $time, wrap, e[12]); end
      if (an    !== e[11:8])  begin fails++; $display("FAIL sb_an t=%0t got %b exp %b", $time, an, e[11:8]); end
      if (seg   !== e[7:1])   begin fails++; $display("FAIL sb_seg t=%0t got %h exp %h", $time, seg, e[7:1]); end
      if (dp    !== e[0])     begin fails++; $display("FAIL sb_dp t=%0t got %b exp %b", $time, dp, e[0]); end
    end
  end

  // driver: set inputs, then let one rising edge sample them
  task automatic cyc(input logic ct, input logic st, input logic cl);
    count_tick = ct;
    scan_tick  = st;
    clear      = cl;
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  task automatic chk_disp(input string name, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    chk({name, "_an"},  {12'd0, an},  {12'd0, e_an});
    chk({name, "_seg"}, {9'd0, seg},  {9'd0, e_seg});
    chk({name, "_dp"},  {15'd0, dp},  {15'd0, e_dp});
  endtask

  logic [3:0] scan_an [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [6:0] scan_seg[4] = '{7'h30, 7'h24, 7'h79, 7'h19};
  logic       scan_dp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [6:0] hi_zero_seg;
  logic       hi_zero_dp2;

  initial begin
    reset_n = 1'b0; enable = 1'b1; up = 1'b1;
    count_tick = 1'b0; scan_tick = 1'b0; clear = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    hi_zero_seg = 7'h7F; hi_zero_dp2 = 1'b1;
`else
    hi_zero_seg = 7'h40; hi_zero_dp2 = 1'b0;
`endif

    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    chk_disp("reset_off", 4'hF, 7'h7F, 1'b1);
    chk("reset_value", value, 16'h0000);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_reset_value", value, 16'h0000);
    chk_disp("post_reset", 4'b1110, 7'h40, 1'b1);

    // up count through 0999 -> 1000 and 9999 -> 0000
    repeat (999) cyc(1'b1, 1'b0, 1'b0);
    chk("up_0999", value, 16'h0999);
    cyc(1'b1, 1'b0, 1'b0);
    chk("up_1000", value, 16'h1000);
    chk("up_1000_wrap", {15'd0, wrap}, 16'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("clear_0000", value, 16'h0000);
    up = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("down_9999", value, 16'h9999);
    chk("down_wrap", {15'd0, wrap}, 16'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("down_9998", value, 16'h9998);
    chk("down_wrap_drop", {15'd0, wrap}, 16'd0);
    up = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("up_9999", value, 16'h9999);
    cyc(1'b1, 1'b0, 1'b0);
    chk("up_wrap_0000", value, 16'h0000);
    chk("up_wrap", {15'd0, wrap}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("up_wrap_one_cycle", {15'd0, wrap}, 16'd0);

    // priority: clear beats count_tick, enable=0 ignores count_tick
    repeat (1234) cyc(1'b1, 1'b0, 1'b0);
    chk("reach_1234", value, 16'h1234);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clear_over_tick", value, 16'h0000);
    chk("clear_wrap", {15'd0, wrap}, 16'd0);
    repeat (1234) cyc(1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("enable_low_hold", value, 16'h1234);
    enable = 1'b1;

    // scan of 1234, decimal point on digit 2
    cyc(1'b0, 1'b0, 1'b0);
    chk_disp("scan_d0", 4'b1110, 7'h19, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk_disp($sformatf("scan_step%0d", i), scan_an[i], scan_seg[i], scan_dp[i]);
    end

    // reset while in DIG2
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_disp("pre_reset_dig2", 4'b1011, 7'h24, 1'b0);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    chk_disp("mid_reset", 4'hF, 7'h7F, 1'b1);
    chk("mid_reset_value", value, 16'h0000);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_disp("after_mid_reset", 4'b1110, 7'h40, 1'b1);

    // 0042: leading-zero behaviour on digits 3 and 2
    repeat (42) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_disp("lz_d0", 4'b1110, 7'h24, 1'b1);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    chk_disp("lz_d1", 4'b1101, 7'h19, 1'b1);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    chk_disp("lz_d2", 4'b1011, hi_zero_seg, hi_zero_dp2);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    chk_disp("lz_d3", 4'b0111, hi_zero_seg, 1'b1);

    // random traffic against the model
    repeat (3000) begin
      reset_n = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 99) == 0));
    end
    reset_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clock_in);
    #1;
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
